alu_rr_scheduler: RTL and testbench

//  Shares one combinational 19-bit ALU (ADD..TNF one-hot control) between NUM_REQ requesters.

---
 rtl/alu_rr_scheduler.sv | 163 ++++++++++++++++
 tb/tb_alu_rr_scheduler.sv | 327 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_rr_scheduler.sv
// ---------------------------------------------------------------------------
// alu_rr_scheduler
//   Shares one external combinational 19-bit ALU between NUM_REQ requesters.
//   A round-robin arbiter accepts one {op, AC, DR} request at a time. The
//   request is replayed to the ALU for a single ISSUE cycle with a one-hot
//   control word. The ALU result and overflow are registered. They are then
//   returned to the winning requester over a valid/ready channel. Only one
//   transaction is in flight at any time.
//
// Ports
//   clk, rst_n   clock (rising edge), asynchronous active-low reset
//   req_valid    per-requester request valid
//   req_ready    per-requester accept strobe (one-hot or zero, combinational)
//   req_op       packed opcodes,  requester i at [i*OP_W   +: OP_W]
//   req_ac       packed AC,       requester i at [i*DATA_W +: DATA_W]
//   req_dr       packed DR,       requester i at [i*DATA_W +: DATA_W]
//   alu_ac/dr    operands to the ALU (zero outside ISSUE)
//   alu_ctl      one-hot ALU strobes, bit0=ADD .. bit13=TNF (zero outside ISSUE)
//   alu_result   ALU output (ALU_OP)
//   alu_ovf      ALU overflow (OVF_FLAG)
//   rsp_valid    per-requester response valid (one-hot or zero)
//   rsp_ready    per-requester response taken
//   rsp_data     registered result
//   rsp_ovf      registered overflow
//   busy         high whenever a transaction is in flight
//   illegal_op   one-cycle pulse while an opcode 14/15 sits in ISSUE
// ---------------------------------------------------------------------------
module alu_rr_scheduler #(
    parameter int NUM_REQ = 2,
    parameter int DATA_W  = 19,
    parameter int OP_W    = 4
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [NUM_REQ-1:0]        req_valid,
    output logic [NUM_REQ-1:0]        req_ready,
    input  logic [NUM_REQ*OP_W-1:0]   req_op,
    input  logic [NUM_REQ*DATA_W-1:0] req_ac,
    input  logic [NUM_REQ*DATA_W-1:0] req_dr,
    output logic [DATA_W-1:0]         alu_ac,
    output logic [DATA_W-1:0]         alu_dr,
    output logic [13:0]               alu_ctl,
    input  logic [DATA_W-1:0]         alu_result,
    input  logic                      alu_ovf,
    output logic [NUM_REQ-1:0]        rsp_valid,
    input  logic [NUM_REQ-1:0]        rsp_ready,
    output logic [DATA_W-1:0]         rsp_data,
    output logic                      rsp_ovf,
    output logic                      busy,
    output logic                      illegal_op
);

    localparam int PTR_W  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int NUM_OP = 14;  // opcodes 0..13 have an ALU strobe

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] ISSUE = 2'd1;
    localparam logic [1:0] RESP  = 2'd2;

    logic [1:0]        state;
    logic [PTR_W-1:0]  rr_ptr;
    logic [PTR_W-1:0]  win_q;
    logic [OP_W-1:0]   op_q;
    logic [DATA_W-1:0] ac_q;
    logic [DATA_W-1:0] dr_q;

    logic              win_found;
    logic [PTR_W-1:0]  win_idx;
    logic              op_legal;

    // (base + off) mod NUM_REQ, with off < NUM_REQ so one subtraction is enough.
    function automatic logic [PTR_W-1:0] wrap_add(input logic [PTR_W-1:0] base,
                                                  input int off);
        int s;
        s = {{(32-PTR_W){1'b0}}, base} + off;
        if (s >= NUM_REQ) s = s - NUM_REQ;
        return s[PTR_W-1:0];
    endfunction

    // Round-robin search: first valid requester at or after rr_ptr, wrapping.
    always_comb begin
        // NOTE: every variable gets a default before any conditional assignment,
        // so no path through the block leaves it unassigned and no latch appears.
        win_found = 1'b0;
        win_idx   = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (!win_found && req_valid[wrap_add(rr_ptr, k)]) begin
                win_found = 1'b1;
                win_idx   = wrap_add(rr_ptr, k);
            end
        end
    end

    // Accept strobe is combinational so a request is taken in the same cycle.
    always_comb begin
        req_ready = '0;
        if (state == IDLE && win_found) req_ready[win_idx] = 1'b1;
    end

    assign op_legal = (op_q < OP_W'(NUM_OP));

    // ALU drive: operands and strobe only during ISSUE, so the ALU idles at 0.
    always_comb begin
        alu_ac  = '0;
        alu_dr  = '0;
        alu_ctl = '0;
        if (state == ISSUE) begin
            alu_ac = ac_q;
            alu_dr = dr_q;
            if (op_legal) alu_ctl = 14'd1 << op_q;
        end
    end

    always_comb begin
        rsp_valid = '0;
        if (state == RESP) rsp_valid[win_q] = 1'b1;
    end

    assign busy       = (state != IDLE);
    assign illegal_op = (state == ISSUE) && !op_legal;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // NOTE: the operand/opcode latches are reset as well; they are few
            // flops and this keeps the ALU-facing outputs defined from reset.
            state    <= IDLE;
            rr_ptr   <= '0;
            win_q    <= '0;
            op_q     <= '0;
            ac_q     <= '0;
            dr_q     <= '0;
            rsp_data <= '0;
            rsp_ovf  <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every register here updates from
            // the pre-edge values, independent of statement order.
            case (state)
                IDLE: begin
                    if (win_found) begin
                        op_q   <= req_op[win_idx*OP_W +: OP_W];
                        ac_q   <= req_ac[win_idx*DATA_W +: DATA_W];
                        dr_q   <= req_dr[win_idx*DATA_W +: DATA_W];
                        win_q  <= win_idx;
                        rr_ptr <= wrap_add(win_idx, 1);
                        state  <= ISSUE;
                    end
                end
                ISSUE: begin
                    // Illegal opcodes return a clean zero response whatever the ALU shows.
                    rsp_data <= op_legal ? alu_result : '0;
                    rsp_ovf  <= op_legal & alu_ovf;
                    state    <= RESP;
                end
                RESP: begin
                    // Only the owning requester's ready can retire the response.
                    if (rsp_ready[win_q]) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_rr_scheduler.sv
// ---------------------------------------------------------------------------
// tb_alu_rr_scheduler
//   Directed bench for alu_rr_scheduler (NUM_REQ=2). Stimulus pushes request
//   payloads into per-requester queues and the hand-computed response into a
//   scoreboard queue in expected grant order; a monitor pops and compares on
//   every response handshake. A small behavioural ALU sits on the ALU port.
// ---------------------------------------------------------------------------
module tb_alu_rr_scheduler;

    localparam logic [3:0] OP_ADD = 4'd0;
    localparam logic [3:0] OP_SUB = 4'd1;
    localparam logic [3:0] OP_MUL = 4'd2;
    localparam logic [3:0] OP_AND = 4'd4;
    localparam logic [3:0] OP_OR  = 4'd5;
    localparam logic [3:0] OP_XOR = 4'd6;

    typedef struct {
        logic [3:0]  op;
        logic [18:0] ac;
        logic [18:0] dr;
    } req_t;

    typedef struct {
        int          who;
        logic [18:0] data;
        logic        ovf;
    } exp_t;

    logic        clk;
    logic        rst_n;
    logic [1:0]  req_valid;
    logic [1:0]  req_ready;
    logic [7:0]  req_op;
    logic [37:0] req_ac;
    logic [37:0] req_dr;
    logic [18:0] alu_ac;
    logic [18:0] alu_dr;
    logic [13:0] alu_ctl;
    logic [18:0] alu_result;
    logic        alu_ovf;
    logic [1:0]  rsp_valid;
    logic [1:0]  rsp_ready;
    logic [18:0] rsp_data;
    logic        rsp_ovf;
    logic        busy;
    logic        illegal_op;

    req_t pend0[$];
    req_t pend1[$];
    exp_t exp_q[$];

    int n_checks = 0;
    int n_fail   = 0;

    alu_rr_scheduler #(.NUM_REQ(2), .DATA_W(19), .OP_W(4)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_op     (req_op),
        .req_ac     (req_ac),
        .req_dr     (req_dr),
        .alu_ac     (alu_ac),
        .alu_dr     (alu_dr),
        .alu_ctl    (alu_ctl),
        .alu_result (alu_result),
        .alu_ovf    (alu_ovf),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_data   (rsp_data),
        .rsp_ovf    (rsp_ovf),
        .busy       (busy),
        .illegal_op (illegal_op)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Behavioural ALU. With no strobe it shows junk derived from the operands,
    // so a response that must be forced to zero is observable.
    always_comb begin
        alu_result = '0;
        alu_ovf    = 1'b0;
        case (alu_ctl)
            14'h0000: begin
                alu_result = alu_ac ^ alu_dr;
                alu_ovf    = |(alu_ac & alu_dr);
            end
            14'h0001: begin
                alu_result = alu_ac + alu_dr;
                alu_ovf    = (alu_ac[18] == alu_dr[18]) && (alu_result[18] != alu_ac[18]);
            end
            14'h0002: begin
                alu_result = alu_ac - alu_dr;
                alu_ovf    = (alu_ac[18] != alu_dr[18]) && (alu_result[18] != alu_ac[18]);
            end
            14'h0004: alu_result = alu_ac * alu_dr;
            14'h0010: alu_result = alu_ac & alu_dr;
            14'h0020: alu_result = alu_ac | alu_dr;
            14'h0040: alu_result = alu_ac ^ alu_dr;
            default:  alu_result = '0;
        endcase
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic fail_now(input string name);
        n_checks++;
        n_fail++;
        $display("FAIL %s: timed out (t=%0t)", name, $time);
    endtask

    task automatic send(input int who, input logic [3:0] op, input logic [18:0] ac,
                        input logic [18:0] dr, input bit track,
                        input logic [18:0] edata, input logic eovf);
        req_t r;
        exp_t e;
        r.op = op; r.ac = ac; r.dr = dr;
        if (who == 0) pend0.push_back(r);
        else          pend1.push_back(r);
        if (track) begin
            e.who = who; e.data = edata; e.ovf = eovf;
            exp_q.push_back(e);
        end
    endtask

    // Returns at the negedge of the cycle in which a request in mask is accepted.
    task automatic wait_ready(input string name, input logic [1:0] mask);
        bit seen = 1'b0;
        for (int i = 0; i < 40 && !seen; i++) begin
            @(negedge clk);
            seen = |(req_ready & mask);
        end
        if (!seen) fail_now(name);
    endtask

    task automatic wait_idle(input string name);
        bit done = 1'b0;
        for (int i = 0; i < 80 && !done; i++) begin
            @(negedge clk);
            done = (exp_q.size() == 0) && (pend0.size() == 0) && (pend1.size() == 0) && !busy;
        end
        if (!done) fail_now(name);
    endtask

    task automatic do_reset(input string name);
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        check({name, "_rsp_valid"}, rsp_valid, 0);
        check({name, "_req_ready"}, req_ready, 0);
        check({name, "_busy"}, busy, 0);
        check({name, "_alu_ctl"}, alu_ctl, 0);
        check({name, "_alu_ac"}, alu_ac, 0);
        check({name, "_rsp_data"}, rsp_data, 0);
        check({name, "_illegal"}, illegal_op, 0);
        @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    // Requester model: presents the head of each queue, pops it after acceptance.
    initial begin : feeder
        logic [1:0] acc;
        req_valid = '0;
        req_op    = '0;
        req_ac    = '0;
        req_dr    = '0;
        forever begin
            @(negedge clk);
            acc = req_ready & req_valid;
            @(posedge clk);
            #1;
            if (acc[0] && pend0.size() > 0) void'(pend0.pop_front());
            if (acc[1] && pend1.size() > 0) void'(pend1.pop_front());
            if (pend0.size() > 0) begin
                req_valid[0]  = 1'b1;
                req_op[3:0]   = pend0[0].op;
                req_ac[18:0]  = pend0[0].ac;
                req_dr[18:0]  = pend0[0].dr;
            end else begin
                req_valid[0]  = 1'b0;
            end
            if (pend1.size() > 0) begin
                req_valid[1]  = 1'b1;
                req_op[7:4]   = pend1[0].op;
                req_ac[37:19] = pend1[0].ac;
                req_dr[37:19] = pend1[0].dr;
            end else begin
                req_valid[1]  = 1'b0;
            end
        end
    end

    // Monitor: invariants every cycle, scoreboard compare on each response handshake.
    always @(negedge clk) begin
        if (rst_n) begin
            check("req_ready_onehot0", {31'd0, $onehot0(req_ready)}, 1);
            check("rsp_valid_onehot0", {31'd0, $onehot0(rsp_valid)}, 1);
            if (!busy) check("alu_ctl_idle", alu_ctl, 0);
            if (|(rsp_valid & rsp_ready)) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL rsp_unexpected: got rsp_valid=0x%0h data=0x%0h expected no response",
                             rsp_valid, rsp_data);
                end else begin
                    exp_t e;
                    logic [1:0] ev;
                    e  = exp_q.pop_front();
                    ev = 2'b01 << e.who;
                    check("rsp_owner", rsp_valid, ev);
                    check("rsp_data", rsp_data, e.data);
                    check("rsp_ovf", rsp_ovf, e.ovf);
                end
            end
        end
    end

    initial begin : stim
        rst_n     = 1'b0;
        rsp_ready = 2'b11;
        do_reset("por");

        // 1: ADD into signed overflow, latency and ISSUE drive.
        send(0, OP_ADD, 19'h3FFFF, 19'h00001, 1'b1, 19'h40000, 1'b1);
        wait_ready("t1_accept", 2'b01);
        check("t1_ctl_idle", alu_ctl, 0);
        @(negedge clk);
        check("t1_busy", busy, 1);
        check("t1_ctl", alu_ctl, 14'h0001);
        check("t1_ac", alu_ac, 19'h3FFFF);
        check("t1_dr", alu_dr, 19'h00001);
        check("t1_no_rsp_yet", rsp_valid, 0);
        @(negedge clk);
        check("t1_latency", rsp_valid, 2'b01);
        check("t1_ctl_resp", alu_ctl, 0);
        wait_idle("t1_drain");

        // 2: truncated MUL from requester 1.
        send(1, OP_MUL, 19'h00003, 19'h7FFFE, 1'b1, 19'h7FFFA, 1'b0);
        wait_ready("t2_accept", 2'b10);
        @(negedge clk);
        check("t2_ctl", alu_ctl, 14'h0004);
        @(negedge clk);
        check("t2_latency", rsp_valid, 2'b10);
        wait_idle("t2_drain");

        // 3: both requesters valid from reset, grant order 0,1,0,1.
        do_reset("t3_rst");
        send(0, OP_SUB, 19'h0000A, 19'h00003, 1'b1, 19'h00007, 1'b0);
        send(1, OP_OR,  19'h00F0F, 19'h0F000, 1'b1, 19'h0FF0F, 1'b0);
        send(0, OP_AND, 19'h0F0F0, 19'h0FF00, 1'b1, 19'h0F000, 1'b0);
        send(1, OP_XOR, 19'h7FFFF, 19'h55555, 1'b1, 19'h2AAAA, 1'b0);
        wait_idle("t3_drain");

        // 4: response back-pressure; a foreign rsp_ready bit must not retire it.
        rsp_ready = 2'b10;
        send(0, OP_ADD, 19'h12345, 19'h00001, 1'b1, 19'h12346, 1'b0);
        wait_ready("t4_accept", 2'b01);
        send(1, OP_SUB, 19'h00005, 19'h00007, 1'b1, 19'h7FFFE, 1'b0);
        @(negedge clk);
        repeat (5) begin
            @(negedge clk);
            check("t4_hold_valid", rsp_valid, 2'b01);
            check("t4_hold_data", rsp_data, 19'h12346);
            check("t4_no_accept", req_ready, 0);
        end
        @(posedge clk);
        #1 rsp_ready = 2'b11;
        @(negedge clk);
        check("t4_still_resp", rsp_valid, 2'b01);
        @(negedge clk);
        check("t4_resume", req_ready, 2'b10);
        wait_idle("t4_drain");

        // 5: illegal opcode 0xE.
        send(0, 4'hE, 19'h11111, 19'h33333, 1'b1, 19'h00000, 1'b0);
        wait_ready("t5_accept", 2'b01);
        check("t5_illegal_idle", illegal_op, 0);
        @(negedge clk);
        check("t5_illegal_pulse", illegal_op, 1);
        check("t5_ctl_issue", alu_ctl, 0);
        check("t5_busy", busy, 1);
        @(negedge clk);
        check("t5_illegal_done", illegal_op, 0);
        check("t5_ctl_resp", alu_ctl, 0);
        check("t5_rsp_valid", rsp_valid, 2'b01);
        wait_idle("t5_drain");

        // 6: reset during ISSUE discards the transaction and the rr pointer.
        send(0, OP_ADD, 19'h00001, 19'h00002, 1'b0, 19'h0, 1'b0);
        wait_ready("t6_accept", 2'b01);
        @(negedge clk);
        check("t6_in_issue", alu_ctl, 14'h0001);
        #2 rst_n = 1'b0;
        #1;
        check("t6_rst_rsp_valid", rsp_valid, 0);
        check("t6_rst_ctl", alu_ctl, 0);
        check("t6_rst_busy", busy, 0);
        check("t6_rst_ac", alu_ac, 0);
        repeat (2) @(negedge clk);
        check("t6_rst_hold_busy", busy, 0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        send(0, OP_ADD, 19'h00100, 19'h00200, 1'b1, 19'h00300, 1'b0);
        send(1, OP_MUL, 19'h00010, 19'h00010, 1'b1, 19'h00100, 1'b0);
        wait_ready("t6_regrant", 2'b11);
        check("t6_first_grant", req_ready, 2'b01);
        wait_idle("t6_drain");

        repeat (3) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
